pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Hazard and stall controller for the five-stage pipeline. It sequences the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers, plus the PC. It detects load-use hazards and taken-branch flushes, and runs a multi-cycle data-memory handshake for the MEM stage. The block is purely control; the pipeline registers consume its enable, flush and bubble outputs.

Parameters:
TIMEOUT, 16, maximum MEM_WAIT cycles without dmem_ack before the controller enters TIMEOUT.
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
CLK  input  1  clock, rising edge
reset  input  1  asynchronous, active-low
ID_Rs  input  5  source register 1 of the instruction in ID
ID_Rt  input  5  source register 2 of the instruction in ID
ID_UsesRt  input  1  ID instruction reads Rt
EXE_MemtoReg  input  1  instruction in EXE is a load
EXE_Rw  input  5  destination register of the EXE instruction
EXE_BranchTaken  input  1  branch in EXE resolved taken
MEM_MemtoReg  input  1  MEM-stage load
MEM_MemWr  input  1  MEM-stage store
dmem_ack  input  1  data memory completes the access this cycle
dmem_req  output  1  data memory access request
PC_En  output  1  PC update enable
IF_ID_En  output  1  IF/ID load enable
IF_ID_Flush  output  1  IF/ID clear to NOP
ID_EXE_En  output  1  ID/EXE load enable
ID_EXE_Flush  output  1  ID/EXE clear to bubble
EXE_MEM_En  output  1  EXE/MEM load enable
MEM_WB_Bubble  output  1  MEM/WB loads a bubble (RegWr=0)
mem_timeout  output  1  sticky error flag
stall_cycles  output  32  performance counter (see Optional Feature)

Behaviour:
- FSM states: RUN, MEM_WAIT, TIMEOUT. State is registered; all other outputs are combinational from state and inputs.
- Reset (reset=0, asynchronous): state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0. While reset is low, all *_En=1, all flushes=0, dmem_req=0, MEM_WB_Bubble=0.
- mem_acc = MEM_MemtoReg | MEM_MemWr.
- load_use = EXE_MemtoReg & (EXE_Rw!=0) & (EXE_Rw==ID_Rs | (ID_UsesRt & EXE_Rw==ID_Rt)).
- RUN:
  - dmem_req=mem_acc.
  - If mem_acc & !dmem_ack: freeze (PC_En=IF_ID_En=ID_EXE_En=EXE_MEM_En=0, flushes=0, MEM_WB_Bubble=1). Next state MEM_WAIT, wait_cnt<=1.
  - Else if EXE_BranchTaken: IF_ID_Flush=1, ID_EXE_Flush=1, all enables=1.
  - Else if load_use: PC_En=0, IF_ID_En=0, ID_EXE_Flush=1, EXE_MEM_En=1.
  - Else: all enables=1, no flush.
  - A single-cycle memory (ack in the same cycle as the request) never stalls.
- MEM_WAIT:
  - dmem_req=1.
  - On dmem_ack: all enables=1, MEM_WB_Bubble=0, branch/load_use rules apply as in RUN. Next state RUN, wait_cnt<=0.
  - Without ack: freeze as above, wait_cnt<=wait_cnt+1.
  - When wait_cnt==TIMEOUT and there is no ack: next state TIMEOUT.
- TIMEOUT: dmem_req=0, full freeze, MEM_WB_Bubble=1, mem_timeout=1. Exits only on reset.
- Priority: memory stall > branch flush > load-use. A branch or load-use hazard held during a freeze is re-evaluated on the release cycle; none is lost.
- A load-use hazard with EXE_Rw=0 never stalls.
- Reset asserted mid-wait aborts the access immediately: dmem_req drops asynchronously.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined: stall_cycles increments once per clock in which PC_En=0, i.e. memory freeze, load-use stall or TIMEOUT. It saturates at 0xFFFFFFFF and clears only on reset.
- When undefined: stall_cycles is constant 0 and no counter logic is built.

Test Plan:
- Load to r5 in EXE, ID reads Rs=5 -> one cycle with PC_En=0, IF_ID_En=0, ID_EXE_Flush=1; next cycle all enables=1. Same case with EXE_Rw=0 -> no stall.
- EXE_BranchTaken=1 together with a load_use condition -> IF_ID_Flush=1 and ID_EXE_Flush=1, PC_En=1 (branch wins).
- MEM load, dmem_ack held low 3 cycles then high -> 3 freeze cycles with MEM_WB_Bubble=1, dmem_req=1 throughout; release cycle all enables=1. stall_cycles=3 with HAZ_PERF_CNT_EN.
- Store with dmem_ack=1 in the same cycle -> no freeze, state stays RUN.
- dmem_ack never asserted, TIMEOUT=16 -> TIMEOUT reached on the 17th stalled cycle: mem_timeout=1, dmem_req=0, freeze persists. Pulse reset low -> RUN, mem_timeout=0.
- Reset asserted during MEM_WAIT -> dmem_req=0 and enables=1 immediately, wait_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard and stall controller for the five-stage pipeline.
//
// Sequences the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.
// Detects load-use hazards and taken-branch flushes. Runs a multi-cycle
// data-memory handshake for the MEM stage, with a sticky timeout.
//
// Optional feature: define HAZ_PERF_CNT_EN to build the saturating stall_cycles
// counter. Without it, stall_cycles is tied to zero.
//
// Ports:
//   CLK, reset                 clock (rising edge), asynchronous active-low reset
//   ID_Rs, ID_Rt, ID_UsesRt    source registers of the ID instruction
//   EXE_MemtoReg, EXE_Rw       EXE instruction is a load / its destination register
//   EXE_BranchTaken            branch in EXE resolved taken
//   MEM_MemtoReg, MEM_MemWr    MEM-stage load / store
//   dmem_ack, dmem_req         data-memory handshake
//   PC_En .. MEM_WB_Bubble     pipeline register enables, flushes and bubble
//   mem_timeout                sticky error flag, cleared only by reset
//   stall_cycles               count of cycles with PC_En low
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        EXE_MemtoReg,
  input  logic [4:0]  EXE_Rw,
  input  logic        EXE_BranchTaken,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_MemWr,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        PC_En,
  output logic        IF_ID_En,
  output logic        IF_ID_Flush,
  output logic        ID_EXE_En,
  output logic        ID_EXE_Flush,
  output logic        EXE_MEM_En,
  output logic        MEM_WB_Bubble,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {StRun, StMemWait, StTimeout} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_acc;
  logic load_use;
  logic freeze;

  assign mem_acc  = MEM_MemtoReg | MEM_MemWr;
  assign load_use = EXE_MemtoReg && (EXE_Rw != 5'd0) &&
                    ((EXE_Rw == ID_Rs) || (ID_UsesRt && (EXE_Rw == ID_Rt)));

  // Memory freeze takes priority over every other hazard in all states.
  assign freeze = ((state_q == StRun) && mem_acc && !dmem_ack) ||
                  ((state_q == StMemWait) && !dmem_ack) ||
                  (state_q == StTimeout);

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_acc && !dmem_ack) begin
          state_d    = StMemWait;
          wait_cnt_d = CNT_W'(1);
        end
      end
      StMemWait: begin
        if (dmem_ack) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = StTimeout;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StTimeout: begin
        state_d = StTimeout;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    dmem_req      = 1'b0;
    PC_En         = 1'b1;
    IF_ID_En      = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EXE_En     = 1'b1;
    ID_EXE_Flush  = 1'b0;
    EXE_MEM_En    = 1'b1;
    MEM_WB_Bubble = 1'b0;
    // Reset low forces the pass-through defaults so an in-flight access aborts at once.
    if (reset) begin
      unique case (state_q)
        StRun:     dmem_req = mem_acc;
        StMemWait: dmem_req = 1'b1;
        default:   dmem_req = 1'b0;
      endcase
      if (freeze) begin
        PC_En         = 1'b0;
        IF_ID_En      = 1'b0;
        ID_EXE_En     = 1'b0;
        EXE_MEM_En    = 1'b0;
        MEM_WB_Bubble = 1'b1;
      end else if (EXE_BranchTaken) begin
        IF_ID_Flush  = 1'b1;
        ID_EXE_Flush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, insert a bubble behind the load.
        PC_En        = 1'b0;
        IF_ID_En     = 1'b0;
        ID_EXE_Flush = 1'b1;
      end
    end
  end

  assign mem_timeout = (state_q == StTimeout);

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (!PC_En && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
